// File: rtl/grid_access_arbiter.sv
// grid_access_arbiter
// Round-robin access to the single-port grid cell RAM shared by the game FSM,
// the snack generator and the VGA renderer. (x,y) is flattened to y*GRID_X+x.
// Off-grid coordinates never reach the RAM: reads answer ROCK, writes are dropped.
// Build option: define GRID_CLEAR_SWEEP_EN to add a full-grid clear sweep after
// reset and on clear_req_i.
module grid_access_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned GRID_X  = 32,
    parameter int unsigned GRID_Y  = 24,
    parameter int unsigned COORD_W = 5,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ-1:0]         req_we_i,
    input  logic [NUM_REQ*COORD_W-1:0] req_x_i,
    input  logic [NUM_REQ*COORD_W-1:0] req_y_i,
    input  logic [NUM_REQ*4-1:0]       req_wdata_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    output logic [3:0]                 rsp_rdata_o,
    output logic                       mem_en_o,
    output logic                       mem_we_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [3:0]                 mem_wdata_o,
    input  logic [3:0]                 mem_rdata_i,
    input  logic                       clear_req_i,
    output logic                       clear_busy_o,
    output logic                       oob_flag_o
);

    localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CELLS     = GRID_X * GRID_Y;
    localparam logic [3:0]  CELL_ROCK = 4'b0010;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic                rsp_rock_q, rsp_rock_d;
    logic                oob_q, oob_d;

    logic                arb_en_c;
    logic                grant_c;
    logic [IDX_W-1:0]    win_c;
    logic [COORD_W-1:0]  win_x_c;
    logic [COORD_W-1:0]  win_y_c;
    logic                win_we_c;
    logic [3:0]          win_wdata_c;
    logic                win_inb_c;
    logic [ADDR_W-1:0]   win_addr_c;

    // Grants are only issued in ARB and never while reset is asserted.
    assign arb_en_c = !rst_i && (state_q == ST_ARB);

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant_c = 1'b0;
        win_c   = last_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!grant_c && req_valid_i[IDX_W'((32'(last_q) + k) % NUM_REQ)]) begin
                grant_c = 1'b1;
                win_c   = IDX_W'((32'(last_q) + k) % NUM_REQ);
            end
        end
        grant_c = grant_c & arb_en_c;
    end

    // Pick the winner's request fields and flatten its coordinates.
    always_comb begin
        win_x_c     = '0;
        win_y_c     = '0;
        win_we_c    = 1'b0;
        win_wdata_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_c) begin
                win_x_c     = req_x_i[i*COORD_W +: COORD_W];
                win_y_c     = req_y_i[i*COORD_W +: COORD_W];
                win_we_c    = req_we_i[i];
                win_wdata_c = req_wdata_i[i*4 +: 4];
            end
        end
        win_inb_c  = (32'(win_x_c) < GRID_X) && (32'(win_y_c) < GRID_Y);
        win_addr_c = ADDR_W'(32'(win_y_c) * GRID_X + 32'(win_x_c));
    end

`ifdef GRID_CLEAR_SWEEP_EN
    logic [ADDR_W-1:0] clr_addr_d;

    // FSM state register and sweep address; reset starts a sweep.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state: clear_req in ARB starts a sweep, last cell returns to ARB.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = '0;
        case (state_q)
            ST_ARB: begin
                if (clear_req_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (32'(clr_addr_q) == CELLS - 1) begin
                    state_d = ST_ARB;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    assign clear_busy_o = (state_q == ST_CLEAR);
`else
    logic unused_clear_req;

    // FSM state register; without the sweep the arbiter is always in ARB.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: nothing ever leaves ARB.
    always_comb begin
        state_d = ST_ARB;
    end

    assign clr_addr_q       = '0;
    assign clear_busy_o     = 1'b0;
    assign unused_clear_req = clear_req_i;
`endif

    // FSM outputs: sweep writes in CLEAR, grant and RAM access in ARB.
    always_comb begin
        req_ready_o = '0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                mem_en_o   = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = clr_addr_q;
            end else if (grant_c) begin
                req_ready_o[win_c] = 1'b1;
                if (win_inb_c) begin
                    mem_en_o    = 1'b1;
                    mem_we_o    = win_we_c;
                    mem_addr_o  = win_addr_c;
                    mem_wdata_o = win_wdata_c;
                end
            end
        end
    end

    // Next values for pointer, read-response pipeline and sticky off-grid flag.
    always_comb begin
        last_d      = last_q;
        rsp_valid_d = '0;
        rsp_rock_d  = 1'b0;
        oob_d       = oob_q;
        if (grant_c) begin
            last_d = win_c;
            if (!win_we_c) begin
                rsp_valid_d = NUM_REQ'(1) << win_c;
                rsp_rock_d  = !win_inb_c;
            end
            if (!win_inb_c) begin
                oob_d = 1'b1;
            end
        end
    end

    // Arbiter registers; reset drops any pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q      <= IDX_W'(NUM_REQ - 1);
            rsp_valid_q <= '0;
            rsp_rock_q  <= 1'b0;
            oob_q       <= 1'b0;
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rock_q  <= rsp_rock_d;
            oob_q       <= oob_d;
        end
    end

    // RAM data arrives the cycle after the grant, aligned with rsp_valid.
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = (|rsp_valid_q) ? (rsp_rock_q ? CELL_ROCK : mem_rdata_i) : 4'b0000;
    assign oob_flag_o  = oob_q;

endmodule
